wb_stage: RTL and testbench

//  Writeback stage. It is the write side of the register file that the decode stage reads.
//  - Accepts one retiring instruction per cycle from the MEM/WB register.
//  - Aligns and extends load data returned by data memory.
//  - Drives the register-file write port (rd_addr_wb / rd_data_wb / rd_wen_wb) one cycle later.
//  - Stalls the pipeline while a load response is outstanding.
//  - Counts retired instructions and halts the core on ECALL or on a load timeout.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/load_align.sv | 39 +++
 rtl/wb_stage.sv | 119 +++++++++++
 tb/tb_wb_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the writeback stage.
//   wb_state_t : writeback FSM states (RUN / WAIT_LOAD / HALT)
//   F3_*       : load funct3 encodings (size and signedness)
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_RUN       = 2'd0,
    WB_WAIT_LOAD = 2'd1,
    WB_HALT      = 2'd2
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment and sign/zero extension.
//   funct3   in  3   load size/sign
//   byte_off in  3   load address [2:0]; low bits below the access size are ignored
//   rdata    in  64  aligned doubleword from data memory
//   result   out 64  extended load value (0 for the invalid funct3 111)
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  byte_off,
  input  logic [63:0] rdata,
  output logic [63:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] word_lane;

  always_comb begin
    byte_lane = rdata[8*byte_off +: 8];
    half_lane = rdata[16*byte_off[2:1] +: 16];
    word_lane = byte_off[2] ? rdata[63:32] : rdata[31:0];
  end

  always_comb begin
    result = '0;
    unique case (funct3)
      F3_LB:   result = {{56{byte_lane[7]}}, byte_lane};
      F3_LH:   result = {{48{half_lane[15]}}, half_lane};
      F3_LW:   result = {{32{word_lane[31]}}, word_lane};
      F3_LD:   result = rdata;
      F3_LBU:  result = {56'd0, byte_lane};
      F3_LHU:  result = {48'd0, half_lane};
      F3_LWU:  result = {32'd0, word_lane};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: write side of the register file.
//   clk, rst                 clock, synchronous active-high reset
//   wb_*                     retiring instruction from the MEM/WB register
//   dmem_rvalid, dmem_rdata  load response from data memory
//   rd_addr_wb/rd_data_wb/rd_wen_wb  registered register-file write port (1-cycle latency)
//   wb_stall                 combinational hold for MEM/WB and upstream while a load is outstanding
//   halted, load_fault       sticky stop indications (ECALL / load timeout)
//   instret                  retired-instruction counter, wraps modulo 2^64
module wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned XLEN         = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic            wb_is_load,
  input  logic [2:0]      wb_funct3,
  input  logic [2:0]      wb_byte_off,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic            wb_ecall,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      rd_addr_wb,
  output logic [XLEN-1:0] rd_data_wb,
  output logic            rd_wen_wb,
  output logic            wb_stall,
  output logic            halted,
  output logic            load_fault,
  output logic [63:0]     instret
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(LOAD_TIMEOUT);

  wb_state_t   state, state_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic        retire;
  logic        fault_set;
  logic [63:0] load_data;

  load_align u_load_align (
    .funct3   (wb_funct3),
    .byte_off (wb_byte_off),
    .rdata    (dmem_rdata),
    .result   (load_data)
  );

  always_comb begin
    retire   = wb_valid && (state != WB_HALT) && (!wb_is_load || dmem_rvalid);
    wb_stall = wb_valid && wb_is_load && !dmem_rvalid && (state != WB_HALT);
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    fault_set     = 1'b0;
    unique case (state)
      WB_RUN: begin
        if (retire && wb_ecall) begin
          state_next = WB_HALT;
        end else if (wb_stall) begin
          state_next    = WB_WAIT_LOAD;
          wait_cnt_next = 8'd1;
        end
      end
      WB_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_next    = (retire && wb_ecall) ? WB_HALT : WB_RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          state_next = WB_HALT;
          fault_set  = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      WB_HALT: begin
        state_next = WB_HALT;
      end
      default: begin
        state_next    = WB_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WB_RUN;
      wait_cnt   <= '0;
      rd_addr_wb <= '0;
      rd_data_wb <= '0;
      rd_wen_wb  <= 1'b0;
      halted     <= 1'b0;
      load_fault <= 1'b0;
      instret    <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      // HALT is absorbing, so the sticky flag simply tracks entry into it.
      halted   <= (state_next == WB_HALT);
      if (fault_set) begin
        load_fault <= 1'b1;
      end
      if (retire) begin
        rd_addr_wb <= wb_rd_addr;
        rd_wen_wb  <= wb_reg_write && (wb_rd_addr != 5'd0);
        rd_data_wb <= wb_is_load ? load_data : wb_alu_result;
        instret    <= instret + 64'd1;
      end else begin
        rd_wen_wb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_write;
  logic        wb_is_load;
  logic [2:0]  wb_funct3;
  logic [2:0]  wb_byte_off;
  logic [63:0] wb_alu_result;
  logic        wb_ecall;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic [4:0]  rd_addr_wb;
  logic [63:0] rd_data_wb;
  logic        rd_wen_wb;
  logic        wb_stall;
  logic        halted;
  logic        load_fault;
  logic [63:0] instret;

  int checks;
  int errors;
  logic [63:0] exp_instret;

  wb_stage #(.LOAD_TIMEOUT(4), .XLEN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_is_load    (wb_is_load),
    .wb_funct3     (wb_funct3),
    .wb_byte_off   (wb_byte_off),
    .wb_alu_result (wb_alu_result),
    .wb_ecall      (wb_ecall),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .rd_addr_wb    (rd_addr_wb),
    .rd_data_wb    (rd_data_wb),
    .rd_wen_wb     (rd_wen_wb),
    .wb_stall      (wb_stall),
    .halted        (halted),
    .load_fault    (load_fault),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wb_valid      = 1'b0;
    wb_rd_addr    = '0;
    wb_reg_write  = 1'b0;
    wb_is_load    = 1'b0;
    wb_funct3     = '0;
    wb_byte_off   = '0;
    wb_alu_result = '0;
    wb_ecall      = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [63:0] val);
    drive_idle();
    wb_valid      = 1'b1;
    wb_rd_addr    = rd;
    wb_reg_write  = 1'b1;
    wb_alu_result = val;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (rd_wen_wb !== 1'b0 || rd_addr_wb !== 5'd0 || rd_data_wb !== 64'd0) begin
      errors++;
      $display("FAIL reset_wport: wen=%b addr=%0d data=%h expected 0/0/0", rd_wen_wb, rd_addr_wb, rd_data_wb);
    end
    checks++;
    if (halted !== 1'b0 || load_fault !== 1'b0 || instret !== 64'd0 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: halted=%b fault=%b instret=%0d stall=%b expected 0", halted, load_fault, instret, wb_stall);
    end
    exp_instret = 64'd0;
  endtask

  task automatic test_alu();
    drive_alu(5'd5, 64'hDEAD);
    checks++;
    if (wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall: got %b expected 0", wb_stall);
    end
    tick();
    exp_instret = exp_instret + 1;
    drive_idle();
    checks++;
    if (rd_wen_wb !== 1'b1 || rd_addr_wb !== 5'd5 || rd_data_wb !== 64'hDEAD || instret !== exp_instret) begin
      errors++;
      $display("FAIL alu_write: wen=%b addr=%0d data=%h instret=%0d expected 1/5/dead/%0d",
               rd_wen_wb, rd_addr_wb, rd_data_wb, instret, exp_instret);
    end
    tick();
    checks++;
    if (rd_wen_wb !== 1'b0 || rd_addr_wb !== 5'd5 || rd_data_wb !== 64'hDEAD || instret !== exp_instret) begin
      errors++;
      $display("FAIL alu_hold: wen=%b addr=%0d data=%h instret=%0d expected 0/5/dead/%0d",
               rd_wen_wb, rd_addr_wb, rd_data_wb, instret, exp_instret);
    end
  endtask

  task automatic test_x0();
    drive_alu(5'd0, 64'h1234);
    tick();
    exp_instret = exp_instret + 1;
    drive_idle();
    checks++;
    if (rd_wen_wb !== 1'b0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL x0_write: wen=%b instret=%0d expected 0/%0d", rd_wen_wb, instret, exp_instret);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3 [8];
    logic [2:0]  off [8];
    logic [63:0] exp [8];
    f3[0] = F3_LB;  off[0] = 3'd0; exp[0] = 64'hFFFF_FFFF_FFFF_FFF0;
    f3[1] = F3_LBU; off[1] = 3'd7; exp[1] = 64'h0000_0000_0000_0080;
    f3[2] = F3_LH;  off[2] = 3'd6; exp[2] = 64'hFFFF_FFFF_FFFF_80FF;
    f3[3] = F3_LWU; off[3] = 3'd4; exp[3] = 64'h0000_0000_80FF_7F01;
    f3[4] = F3_LW;  off[4] = 3'd1; exp[4] = 64'hFFFF_FFFF_8000_00F0;
    f3[5] = F3_LHU; off[5] = 3'd2; exp[5] = 64'h0000_0000_0000_8000;
    f3[6] = F3_LD;  off[6] = 3'd5; exp[6] = 64'h80FF_7F01_8000_00F0;
    f3[7] = 3'b111; off[7] = 3'd0; exp[7] = 64'h0;
    for (int i = 0; i < 8; i++) begin
      drive_idle();
      wb_valid     = 1'b1;
      wb_is_load   = 1'b1;
      wb_reg_write = 1'b1;
      wb_rd_addr   = 5'(10 + i);
      wb_funct3    = f3[i];
      wb_byte_off  = off[i];
      dmem_rvalid  = 1'b1;
      dmem_rdata   = 64'h80FF_7F01_8000_00F0;
      checks++;
      if (wb_stall !== 1'b0) begin
        errors++;
        $display("FAIL load_ext_stall[%0d]: got %b expected 0", i, wb_stall);
      end
      tick();
      exp_instret = exp_instret + 1;
      checks++;
      if (rd_wen_wb !== 1'b1 || rd_addr_wb !== 5'(10 + i) || rd_data_wb !== exp[i] || instret !== exp_instret) begin
        errors++;
        $display("FAIL load_ext[%0d]: wen=%b addr=%0d data=%h instret=%0d expected 1/%0d/%h/%0d",
                 i, rd_wen_wb, rd_addr_wb, rd_data_wb, instret, 10 + i, exp[i], exp_instret);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_load_latency();
    int stall_cycles;
    stall_cycles = 0;
    drive_idle();
    wb_valid     = 1'b1;
    wb_is_load   = 1'b1;
    wb_reg_write = 1'b1;
    wb_rd_addr   = 5'd7;
    wb_funct3    = F3_LD;
    dmem_rdata   = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      if (wb_stall === 1'b1) stall_cycles++;
      tick();
      checks++;
      if (rd_wen_wb !== 1'b0 || instret !== exp_instret) begin
        errors++;
        $display("FAIL latency_no_early_write[%0d]: wen=%b instret=%0d expected 0/%0d", c, rd_wen_wb, instret, exp_instret);
      end
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h1122_3344_5566_7788;
    if (wb_stall === 1'b1) stall_cycles++;
    checks++;
    if (stall_cycles !== 3) begin
      errors++;
      $display("FAIL latency_stall_cycles: got %0d expected 3", stall_cycles);
    end
    tick();
    exp_instret = exp_instret + 1;
    drive_idle();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'hFFFF_0000_FFFF_0000;
    checks++;
    if (rd_wen_wb !== 1'b1 || rd_addr_wb !== 5'd7 || rd_data_wb !== 64'h1122_3344_5566_7788 || instret !== exp_instret) begin
      errors++;
      $display("FAIL latency_write: wen=%b addr=%0d data=%h instret=%0d expected 1/7/1122334455667788/%0d",
               rd_wen_wb, rd_addr_wb, rd_data_wb, instret, exp_instret);
    end
    tick();
    checks++;
    if (rd_wen_wb !== 1'b0 || rd_data_wb !== 64'h1122_3344_5566_7788 || instret !== exp_instret) begin
      errors++;
      $display("FAIL latency_single_write: wen=%b data=%h instret=%0d expected 0/1122334455667788/%0d",
               rd_wen_wb, rd_data_wb, instret, exp_instret);
    end
    drive_idle();
  endtask

  task automatic test_ecall_and_reset();
    drive_idle();
    wb_valid = 1'b1;
    wb_ecall = 1'b1;
    tick();
    exp_instret = exp_instret + 1;
    checks++;
    if (halted !== 1'b1 || instret !== exp_instret || rd_wen_wb !== 1'b0 || load_fault !== 1'b0) begin
      errors++;
      $display("FAIL ecall_halt: halted=%b instret=%0d wen=%b fault=%b expected 1/%0d/0/0",
               halted, instret, rd_wen_wb, load_fault, exp_instret);
    end
    drive_alu(5'd9, 64'h55);
    tick();
    checks++;
    if (halted !== 1'b1 || instret !== exp_instret || rd_wen_wb !== 1'b0) begin
      errors++;
      $display("FAIL ecall_absorb: halted=%b instret=%0d wen=%b expected 1/%0d/0", halted, instret, rd_wen_wb, exp_instret);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_instret = 64'd0;
    drive_idle();
    checks++;
    if (halted !== 1'b0 || instret !== 64'd0 || rd_wen_wb !== 1'b0 || rd_addr_wb !== 5'd0 || rd_data_wb !== 64'd0) begin
      errors++;
      $display("FAIL ecall_reset: halted=%b instret=%0d wen=%b addr=%0d data=%h expected all 0",
               halted, instret, rd_wen_wb, rd_addr_wb, rd_data_wb);
    end
    drive_alu(5'd3, 64'hABC);
    tick();
    exp_instret = exp_instret + 1;
    drive_idle();
    checks++;
    if (rd_wen_wb !== 1'b1 || rd_data_wb !== 64'hABC || instret !== exp_instret) begin
      errors++;
      $display("FAIL reset_run: wen=%b data=%h instret=%0d expected 1/abc/%0d", rd_wen_wb, rd_data_wb, instret, exp_instret);
    end
  endtask

  task automatic test_timeout();
    drive_idle();
    wb_valid     = 1'b1;
    wb_is_load   = 1'b1;
    wb_reg_write = 1'b1;
    wb_rd_addr   = 5'd12;
    wb_funct3    = F3_LD;
    // One RUN cycle plus WAIT_LOAD with wait_cnt 1..4 before the fault.
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (halted !== 1'b0 || load_fault !== 1'b0 || wb_stall !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early[%0d]: halted=%b fault=%b stall=%b expected 0/0/1", c, halted, load_fault, wb_stall);
      end
    end
    tick();
    checks++;
    if (halted !== 1'b1 || load_fault !== 1'b1 || rd_wen_wb !== 1'b0 || instret !== exp_instret || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fault: halted=%b fault=%b wen=%b instret=%0d stall=%b expected 1/1/0/%0d/0",
               halted, load_fault, rd_wen_wb, instret, exp_instret, wb_stall);
    end
    dmem_rvalid = 1'b1;
    tick();
    drive_alu(5'd4, 64'h77);
    tick();
    tick();
    checks++;
    if (halted !== 1'b1 || load_fault !== 1'b1 || rd_wen_wb !== 1'b0 || instret !== exp_instret || rd_data_wb !== 64'hABC) begin
      errors++;
      $display("FAIL timeout_ignore: halted=%b fault=%b wen=%b instret=%0d data=%h expected 1/1/0/%0d/abc",
               halted, load_fault, rd_wen_wb, instret, exp_instret, rd_data_wb);
    end
    drive_idle();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_instret = '0;
    rst         = 1'b1;
    drive_idle();
    #1;
    test_reset();
    test_alu();
    test_x0();
    test_load_ext();
    test_load_latency();
    test_ecall_and_reset();
    test_timeout();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
